// File: rtl/movavg_sched_if.sv
// Request/result bus for movavg_sched: NCH sample ports in, one tagged result port out.
// A transfer on any port happens on a rising clk edge where valid and ready are both 1.
// The source holds valid and data stable until that edge. The sink may drive ready from valid.
interface movavg_sched_if #(
  parameter int NCH = 4,
  parameter int W   = 64
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]   req_valid;
  logic [NCH-1:0]   req_ready;
  logic [NCH*W-1:0] req_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [CW-1:0]    out_ch;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/movavg_sched.sv
// Round-robin shared 4-tap moving-average engine serving NCH channels with one adder.
// Define MOVAVG_SCHED_AVG_EN to output the mean (sum >> 2) instead of the raw sum.
module movavg_sched #(
  parameter int NCH = 4,
  parameter int W   = 64,
  localparam int CW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  movavg_sched_if.slave    bus,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    ACC2 = 3'd2,
    ACC3 = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] rr;
  logic [CW-1:0] cur;
  logic [CW-1:0] grant_idx;
  logic          grant_found;
  logic [CW:0]   cand;
  logic [W-1:0]  grant_data;
  logic [W-1:0]  acc;
  logic [W-1:0]  smp;
  logic [W-1:0]  tap1 [NCH];
  logic [W-1:0]  tap2 [NCH];
  logic [W-1:0]  tap3 [NCH];

  // Search starts just past the last granted channel and wraps modulo NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = {1'b0, rr} + (CW+1)'(k);
      if (cand >= (CW+1)'(NCH)) cand = cand - (CW+1)'(NCH);
      if (!grant_found && bus.req_valid[cand[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[CW-1:0];
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == CW'(i)) grant_data = bus.req_data[i*W +: W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = ACC1;
      ACC1:    state_nxt = ACC2;
      ACC2:    state_nxt = ACC3;
      ACC3:    state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by reset so nothing is offered while the block is held in reset.
  always_comb begin
    bus.req_ready = '0;
    if (reset && state == IDLE && grant_found) bus.req_ready[grant_idx] = 1'b1;
    bus.out_valid = (state == OUT);
    bus.out_data  = '0;
    if (state == OUT) begin
`ifdef MOVAVG_SCHED_AVG_EN
      bus.out_data = acc >> 2;
`else
      bus.out_data = acc;
`endif
    end
    bus.out_ch = cur;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
      smp <= '0;
      cur <= '0;
      rr  <= CW'(NCH-1);
      for (int i = 0; i < NCH; i++) begin
        tap1[i] <= '0;
        tap2[i] <= '0;
        tap3[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            acc <= grant_data;
            smp <= grant_data;
            cur <= grant_idx;
            rr  <= grant_idx;
          end
        end
        ACC1: acc <= acc + tap1[cur];
        ACC2: acc <= acc + tap2[cur];
        ACC3: acc <= acc + tap3[cur];
        OUT: begin
          // History only advances once the result has been taken downstream.
          if (bus.out_ready) begin
            tap3[cur] <= tap2[cur];
            tap2[cur] <= tap1[cur];
            tap1[cur] <= smp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_movavg_sched.sv
// Self-checking bench for movavg_sched: per-channel history model feeding an expected-result queue.
// Build with MOVAVG_SCHED_AVG_EN defined to check the mean-output variant.
module tb_movavg_sched;
  localparam int NCH = 4;
  localparam int W   = 64;
  localparam int CW  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic busy;

  movavg_sched_if #(.NCH(NCH), .W(W)) bus();

  movavg_sched #(.NCH(NCH), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int last_acc_cyc = 0;
  logic prev_ov = 1'b0;
  logic [CW+W-1:0] exp_q[$];
  logic [W-1:0]    out_log[$];
  int              grant_log[$];
  logic [W-1:0]    mh1 [NCH];
  logic [W-1:0]    mh2 [NCH];
  logic [W-1:0]    mh3 [NCH];

  function automatic logic [W-1:0] model_out(input logic [W-1:0] sum);
`ifdef MOVAVG_SCHED_AVG_EN
    return sum >> 2;
`else
    return sum;
`endif
  endfunction

  // Scoreboard: model taps advance at accept, results compared when handed downstream.
  task automatic monitor();
    logic [W-1:0] sum;
    logic [CW+W-1:0] e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!reset) begin
        exp_q.delete();
        for (int i = 0; i < NCH; i++) begin
          mh1[i] = '0; mh2[i] = '0; mh3[i] = '0;
        end
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) begin
            sum = bus.req_data[i*W +: W] + mh1[i] + mh2[i] + mh3[i];
            exp_q.push_back({CW'(i), model_out(sum)});
            mh3[i] = mh2[i];
            mh2[i] = mh1[i];
            mh1[i] = bus.req_data[i*W +: W];
            grant_log.push_back(i);
            last_acc_cyc = ncyc;
          end
        end
        checks++;
        if ($countones(bus.req_ready) > 1) begin
          errors++;
          $display("FAIL ready_onehot got=%b want=at_most_one_bit", bus.req_ready);
        end
        if (bus.out_valid && !prev_ov) begin
          checks++;
          if (ncyc - last_acc_cyc != 4) begin
            errors++;
            $display("FAIL latency got=%0d want=4", ncyc - last_acc_cyc);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out got ch=%0d data=%0h want=none", bus.out_ch, bus.out_data);
          end else begin
            e = exp_q.pop_front();
            if ({bus.out_ch, bus.out_data} !== e) begin
              errors++;
              $display("FAIL out_result got ch=%0d data=%0h want ch=%0d data=%0h",
                       bus.out_ch, bus.out_data, e[CW+W-1:W], e[W-1:0]);
            end
          end
          out_log.push_back(bus.out_data);
        end
      end
      prev_ov = bus.out_valid;
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    grant_log.delete();
    out_log.delete();
  endtask

  task automatic drive_sample(input int ch, input logic [W-1:0] d);
    bit got = 1'b0;
    @(posedge clk); #1;
    bus.req_valid[ch] = 1'b1;
    bus.req_data[ch*W +: W] = d;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ready[ch]) got = 1'b1;
    end
    @(posedge clk); #1;
    bus.req_valid[ch] = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout ch=%0d got=0 want=1", ch);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 80 && !done; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout got pending=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    bus.req_valid = '1;
    bus.req_data  = '1;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b ov=%b od=%0h busy=%b want 0,0,0,0",
               bus.req_ready, bus.out_valid, bus.out_data, busy);
    end
    bus.req_valid = '0;
    reset_dut();
  endtask

  task automatic test_single_ch();
    logic [W-1:0] want [5];
`ifdef MOVAVG_SCHED_AVG_EN
    want = '{64'd0, 64'd0, 64'd1, 64'd2, 64'd3};
`else
    want = '{64'd1, 64'd3, 64'd6, 64'd10, 64'd14};
`endif
    reset_dut();
    for (int v = 1; v <= 5; v++) drive_sample(0, 64'(v));
    wait_drain();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_log.size() <= i || out_log[i] !== want[i]) begin
        errors++;
        $display("FAIL single_ch_out%0d got=%0h want=%0h", i,
                 (out_log.size() > i) ? out_log[i] : '0, want[i]);
      end
    end
  endtask

  task automatic test_two_ch();
    int c0, c1;
    int want_g [4] = '{0, 1, 0, 1};
    logic [W-1:0] want [4];
`ifdef MOVAVG_SCHED_AVG_EN
    want = '{64'd2, 64'd25, 64'd5, 64'd50};
`else
    want = '{64'd10, 64'd100, 64'd20, 64'd200};
`endif
    reset_dut();
    @(posedge clk); #1;
    bus.req_data[0*W +: W] = 64'd10;
    bus.req_data[1*W +: W] = 64'd100;
    bus.req_valid[1:0] = 2'b11;
    for (int n = 0; n < 80 && grant_log.size() < 4; n++) begin
      @(posedge clk); #1;
      c0 = 0; c1 = 0;
      foreach (grant_log[j]) begin
        if (grant_log[j] == 0) c0++;
        if (grant_log[j] == 1) c1++;
      end
      if (c0 >= 2) bus.req_valid[0] = 1'b0;
      if (c1 >= 2) bus.req_valid[1] = 1'b0;
    end
    bus.req_valid = '0;
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grant_log.size() <= i || grant_log[i] != want_g[i] || out_log.size() <= i || out_log[i] !== want[i]) begin
        errors++;
        $display("FAIL two_ch_%0d got grant=%0d data=%0h want grant=%0d data=%0h", i,
                 (grant_log.size() > i) ? grant_log[i] : -1,
                 (out_log.size() > i) ? out_log[i] : '0, want_g[i], want[i]);
      end
    end
  endtask

  task automatic test_all_ch();
    int want_g [5] = '{0, 1, 2, 3, 0};
    reset_dut();
    @(posedge clk); #1;
    for (int i = 0; i < NCH; i++) bus.req_data[i*W +: W] = {$urandom(), $urandom()};
    bus.req_valid = '1;
    for (int n = 0; n < 100 && grant_log.size() < 5; n++) @(posedge clk);
    #1 bus.req_valid = '0;
    wait_drain();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (grant_log.size() <= i || grant_log[i] != want_g[i]) begin
        errors++;
        $display("FAIL all_ch_grant%0d got=%0d want=%0d", i,
                 (grant_log.size() > i) ? grant_log[i] : -1, want_g[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    logic [W-1:0] want;
`ifdef MOVAVG_SCHED_AVG_EN
    want = 64'd1;
`else
    want = 64'd5;
`endif
    reset_dut();
    bus.out_ready = 1'b0;
    drive_sample(2, 64'd5);
    bus.req_valid[0] = 1'b1;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL bp_out_valid_timeout got=0 want=1");
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== want || bus.out_ch !== 2'd2 ||
          bus.req_ready !== '0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b od=%0h ch=%0d rdy=%b busy=%b want 1,%0h,2,0000,1",
                 n, bus.out_valid, bus.out_data, bus.out_ch, bus.req_ready, busy, want);
      end
    end
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got busy=%b ov=%b want 0,0", busy, bus.out_valid);
    end
    wait_drain();
  endtask

  task automatic test_wrap();
    reset_dut();
    drive_sample(0, '1);
    drive_sample(0, 64'd1);
    wait_drain();
    checks++;
    if (out_log.size() < 2 || out_log[1] !== '0) begin
      errors++;
      $display("FAIL wrap got=%0h want=0", (out_log.size() > 1) ? out_log[1] : '1);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    drive_sample(0, 64'd9);
    @(negedge clk);
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before got=%b want=1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got busy=%b ov=%b rdy=%b want 0,0,0", busy, bus.out_valid, bus.req_ready);
    end
    @(posedge clk); #1 reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_output cyc%0d got=%b want=0", n, bus.out_valid);
      end
    end
    out_log.delete();
    drive_sample(0, 64'd7);
    wait_drain();
    checks++;
    if (out_log.size() < 1 || out_log[0] !== model_out(64'd7)) begin
      errors++;
      $display("FAIL mid_after got=%0h want=%0h", (out_log.size() > 0) ? out_log[0] : '1, model_out(64'd7));
    end
  endtask

  task automatic test_four_samples();
    logic [W-1:0] want [4];
`ifdef MOVAVG_SCHED_AVG_EN
    want = '{64'd1, 64'd3, 64'd6, 64'd10};
`else
    want = '{64'd4, 64'd12, 64'd24, 64'd40};
`endif
    reset_dut();
    for (int v = 1; v <= 4; v++) drive_sample(0, 64'(4 * v));
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_log.size() <= i || out_log[i] !== want[i]) begin
        errors++;
        $display("FAIL four_samples_out%0d got=%0h want=%0h", i,
                 (out_log.size() > i) ? out_log[i] : '0, want[i]);
      end
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_single_ch();
    test_two_ch();
    test_all_ch();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_four_samples();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
